// File: rtl/apb4_master_bridge.sv
// Valid/ready request to APB4 master bridge: one transfer in flight, buffered response,
// optional ACCESS-phase timeout.
module apb4_master_bridge #(
  parameter int unsigned REGWIDTH       = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [REGWIDTH-1:0]     req_wdata,
  input  logic [REGWIDTH/8-1:0]   req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [REGWIDTH-1:0]     rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [REGWIDTH-1:0]     m_apb_pwdata,
  output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr,
  input  logic [REGWIDTH-1:0]     m_apb_prdata
);

  localparam int unsigned STRB_W = REGWIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [REGWIDTH-1:0]   r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [2:0]            r_pprot;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [REGWIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;

  // Bridge FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pprot       <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && req_valid) begin
            r_req_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_pwrite    <= req_write;
            r_paddr     <= req_addr;
            r_pprot     <= req_prot;
            r_pwdata    <= req_write ? req_wdata : '0;
            r_pstrb     <= req_write ? req_strb : '0;
            r_cnt       <= '0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle
          if (m_apb_pready) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : m_apb_prdata;
            r_rsp_err     <= m_apb_pslverr;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RESP;
          end else if (TMO_EN && (r_cnt == CNT_LAST)) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else if (TMO_EN) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign rsp_timeout   = r_rsp_timeout;
  assign m_apb_psel    = r_psel;
  assign m_apb_penable = r_penable;
  assign m_apb_pwrite  = r_pwrite;
  assign m_apb_pprot   = r_pprot;
  assign m_apb_paddr   = r_paddr;
  assign m_apb_pwdata  = r_pwdata;
  assign m_apb_pstrb   = r_pstrb;

endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Converts a simple valid/ready request/response interface into APB4 master transfers for one APB4 completer, typically the register block. Each request is registered and driven through the APB SETUP and ACCESS phases. The completer's result, or a bridge-generated timeout error, is returned on a buffered response channel. One transfer is outstanding at a time.

## Interface
Parameters:
- REGWIDTH, 32, data width in bits; multiple of 8
- ADDR_WIDTH, 8, APB address width
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address, passed through unmodified
- req_wdata  in  REGWIDTH  write data
- req_strb  in  REGWIDTH/8  write byte strobes
- req_prot  in  3  APB protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  REGWIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  pslverr, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- m_apb_psel, m_apb_penable, m_apb_pwrite  out  1 each  APB control
- m_apb_pprot  out  3
- m_apb_paddr  out  ADDR_WIDTH
- m_apb_pwdata  out  REGWIDTH
- m_apb_pstrb  out  REGWIDTH/8
- m_apb_pready, m_apb_pslverr  in  1 each
- m_apb_prdata  in  REGWIDTH

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture write, addr, wdata, strb and prot into the APB output registers, then go to SETUP.
  - For reads, force pstrb=0 and pwdata=0.
- SETUP: psel=1, penable=0. Go to ACCESS unconditionally.
- ACCESS: psel=1, penable=1.
  - On pready=1: capture prdata (reads only; writes capture 0) and pslverr into the response registers, then go to RESP.
  - Timeout counter is cleared on entry to SETUP and increments on each ACCESS cycle with pready=0.
  - When the counter equals TIMEOUT_CYCLES-1 and pready=0: abort with rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to RESP.
  - pready=1 in the abort cycle wins; the transfer is normal, not a timeout.
  - With TIMEOUT_CYCLES=0, the bridge waits indefinitely.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - Response fields are held stable until rsp_ready=1, then go to IDLE.
- paddr, pwrite, pprot, pwdata and pstrb hold their captured values from acceptance until the next acceptance.
- pslverr is sampled only in the pready cycle.
- prdata is ignored in all other cycles.

## Timing
- Reset is asserted asynchronously and takes effect immediately. All outputs go to 0 and the state goes to IDLE. req_ready rises to 1 in the first clock after deassertion.
- Reset mid-transfer abandons the APB transfer: psel drops at once and no response is produced.
- Zero-wait-state latency, counting the acceptance edge as cycle 0:
  - SETUP in cycle 1.
  - ACCESS in cycle 2 with pready=1.
  - rsp_valid in cycle 3.
- Each wait state adds one cycle.
- After the rsp_valid/rsp_ready handshake in cycle N, req_ready=1 in cycle N+1. Peak throughput is one transfer per 4 cycles.
- A timeout with TIMEOUT_CYCLES=T gives exactly T ACCESS cycles, with rsp_valid in the cycle after the last one.
- req_ready=0 in SETUP, ACCESS and RESP. Requests presented then are not consumed.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Write 0xDEADBEEF, strb 0xF, to addr 0x04 with pready tied 1:
  - psel/penable sequence is 10 then 11.
  - pwdata=0xDEADBEEF, pstrb=0xF.
  - rsp_valid 3 cycles after acceptance with rsp_err=0, rsp_rdata=0.
- Read addr 0x00, completer returns 0x12345678 with 3 wait states:
  - ACCESS lasts 4 cycles.
  - pstrb=0.
  - rsp_rdata=0x12345678, rsp_err=0.
- Read with pslverr=1 in the pready cycle:
  - rsp_err=1, rsp_timeout=0.
  - rsp_rdata equals the prdata present in that cycle.
- pready held 0 with TIMEOUT_CYCLES=16:
  - exactly 16 ACCESS cycles.
  - psel drops.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with pready=1 in the 16th ACCESS cycle: normal completion, rsp_timeout=0.
- rsp_ready held 0 for 5 cycles with a new req_valid pending:
  - response fields stable throughout.
  - req_ready=0 throughout.
  - second transfer starts the cycle after the handshake.
- rst asserted during ACCESS:
  - all outputs are 0 immediately.
  - no rsp_valid after release.
  - a following write completes normally.
